// File: rtl/mpc_sample_scheduler.sv
// -----------------------------------------------------------------------------
// mpc_sample_scheduler
//
// Purpose:
//   Generates the periodic MPC trigger for the DC-DC control loop. Every
//   period_r cycles it pulses o_mpc_tick for one cycle, snapshots Vpv/Ipv/Vout,
//   and offers the snapshot to the MPC core over a valid/ready handshake. If a
//   new snapshot overwrites one the core has not taken yet, a sticky overrun
//   flag is raised. i_Vout is also passed straight through to o_Vout.
//
// Ports:
//   i_clk, i_reset_n       clock and synchronous active-low reset
//   i_enable               1 = scheduler running, 0 = idle
//   i_period/_load         new period value and its load strobe (values < 2 ignored)
//   i_Vpv/i_Ipv/i_Vout     live converter measurements
//   o_Vout                 combinational copy of i_Vout
//   o_mpc_tick             one-cycle MPC trigger pulse
//   o_sample_valid         snapshot available; i_sample_ready accepts it
//   o_Vpv_s/_Ipv_s/_Vout_s captured snapshot
//   o_overrun              sticky overwrite flag, cleared by i_overrun_clr
//   o_tick_count           number of ticks issued, wraps
// -----------------------------------------------------------------------------
module mpc_sample_scheduler #(
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = 4096
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic [CNT_W-1:0]  i_period,
  input  logic              i_period_load,
  input  logic [DATA_W-1:0] i_Vpv,
  input  logic [DATA_W-1:0] i_Ipv,
  input  logic [DATA_W-1:0] i_Vout,
  output logic [DATA_W-1:0] o_Vout,
  output logic              o_mpc_tick,
  output logic              o_sample_valid,
  input  logic              i_sample_ready,
  output logic [DATA_W-1:0] o_Vpv_s,
  output logic [DATA_W-1:0] o_Ipv_s,
  output logic [DATA_W-1:0] o_Vout_s,
  output logic              o_overrun,
  input  logic              i_overrun_clr,
  output logic [CNT_W-1:0]  o_tick_count
);

  localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t             state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [CNT_W-1:0]   period_q,   period_d;
  logic [CNT_W-1:0]   shadow_q,   shadow_d;
  logic               tick_q,     tick_d;
  logic               valid_q,    valid_d;
  logic [DATA_W-1:0]  vpv_q,      vpv_d;
  logic [DATA_W-1:0]  ipv_q,      ipv_d;
  logic [DATA_W-1:0]  vout_q,     vout_d;
  logic               overrun_q,  overrun_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic               capture;
  logic               accept;

  assign accept = valid_q & i_sample_ready;

  // Next-state logic. The wrap cycle (counter at period_r-1) is the only
  // point where a running period may change length, so a mid-period load
  // never truncates or stretches the period in flight. Dropping i_enable
  // takes precedence over the wrap, so no tick escapes on the way to IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    shadow_d   = shadow_q;
    valid_d    = valid_q;
    vpv_d      = vpv_q;
    ipv_d      = ipv_q;
    vout_d     = vout_q;
    overrun_d  = overrun_q;
    tick_cnt_d = tick_cnt_q;
    capture    = 1'b0;

    if (i_period_load && (i_period >= MIN_PERIOD)) begin
      shadow_d = i_period;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        period_d = shadow_q;
        if (i_enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == (period_q - CNT_W'(1))) begin
          cnt_d    = '0;
          capture  = 1'b1;
          period_d = shadow_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    tick_d = capture;

    // A capture always leaves a valid snapshot, whether or not the old one
    // was consumed on the same edge; only a plain accept empties the slot.
    if (capture) begin
      vpv_d      = i_Vpv;
      ipv_d      = i_Ipv;
      vout_d     = i_Vout;
      valid_d    = 1'b1;
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
    end else if (accept) begin
      valid_d = 1'b0;
    end

    // Set has priority over clear so a fresh overwrite is never lost.
    if (capture && valid_q && !accept) begin
      overrun_d = 1'b1;
    end else if (i_overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset. Reset
  // drops any pending snapshot and restores the default period in both the
  // active and shadow registers, discarding an unapplied load.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      period_q   <= DEF_PERIOD;
      shadow_q   <= DEF_PERIOD;
      tick_q     <= 1'b0;
      valid_q    <= 1'b0;
      vpv_q      <= '0;
      ipv_q      <= '0;
      vout_q     <= '0;
      overrun_q  <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      shadow_q   <= shadow_d;
      tick_q     <= tick_d;
      valid_q    <= valid_d;
      vpv_q      <= vpv_d;
      ipv_q      <= ipv_d;
      vout_q     <= vout_d;
      overrun_q  <= overrun_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign o_Vout         = i_Vout;
  assign o_mpc_tick     = tick_q;
  assign o_sample_valid = valid_q;
  assign o_Vpv_s        = vpv_q;
  assign o_Ipv_s        = ipv_q;
  assign o_Vout_s       = vout_q;
  assign o_overrun      = overrun_q;
  assign o_tick_count   = tick_cnt_q;

endmodule

// File: tb/tb_mpc_sample_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mpc_sample_scheduler
//
// Directed bench for mpc_sample_scheduler with the default parameters.
// Inputs change just after a falling edge and outputs are observed on falling
// edges, so every rising edge sees stable stimulus. Expected values are the
// hand-derived tick spacings, captured data and flag states of each scenario.
// -----------------------------------------------------------------------------
module tb_mpc_sample_scheduler;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int DEF_P  = 4096;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic              i_enable;
  logic [CNT_W-1:0]  i_period;
  logic              i_period_load;
  logic [DATA_W-1:0] i_Vpv;
  logic [DATA_W-1:0] i_Ipv;
  logic [DATA_W-1:0] i_Vout;
  logic [DATA_W-1:0] o_Vout;
  logic              o_mpc_tick;
  logic              o_sample_valid;
  logic              i_sample_ready;
  logic [DATA_W-1:0] o_Vpv_s;
  logic [DATA_W-1:0] o_Ipv_s;
  logic [DATA_W-1:0] o_Vout_s;
  logic              o_overrun;
  logic              i_overrun_clr;
  logic [CNT_W-1:0]  o_tick_count;

  int testCount = 0;
  int failCount = 0;
  int expTicks  = 0;
  int waited;

  mpc_sample_scheduler #(
    .DATA_W         (DATA_W),
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (DEF_P)
  ) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_enable       (i_enable),
    .i_period       (i_period),
    .i_period_load  (i_period_load),
    .i_Vpv          (i_Vpv),
    .i_Ipv          (i_Ipv),
    .i_Vout         (i_Vout),
    .o_Vout         (o_Vout),
    .o_mpc_tick     (o_mpc_tick),
    .o_sample_valid (o_sample_valid),
    .i_sample_ready (i_sample_ready),
    .o_Vpv_s        (o_Vpv_s),
    .o_Ipv_s        (o_Ipv_s),
    .o_Vout_s       (o_Vout_s),
    .o_overrun      (o_overrun),
    .i_overrun_clr  (i_overrun_clr),
    .o_tick_count   (o_tick_count)
  );

  // Free-running 100 MHz clock.
  always #5 i_clk = ~i_clk;

  // Compare one observed value with its expected value and log any failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the three measurement inputs that the next tick will capture.
  task automatic applyStimulus(input logic [31:0] vpv, input logic [31:0] ipv,
                               input logic [31:0] vout);
    i_Vpv  = vpv;
    i_Ipv  = ipv;
    i_Vout = vout;
  endtask

  // Advance n falling edges.
  task automatic stepCycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Advance at least one cycle, then keep going until a tick is seen or the
  // limit runs out; a timeout returns the limit, which the caller's
  // comparison against the expected spacing then rejects.
  task automatic waitTick(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge i_clk);
      cycles++;
    end while ((o_mpc_tick !== 1'b1) && (cycles < limit));
  endtask

  // Directed scenario sequence, from reset through all handshake corners.
  initial begin
    i_reset_n      = 1'b0;
    i_enable       = 1'b0;
    i_period       = '0;
    i_period_load  = 1'b0;
    i_sample_ready = 1'b1;
    i_overrun_clr  = 1'b0;
    applyStimulus(32'h11, 32'h22, 32'h33);
    stepCycles(3);

    $display("[TB] reset state");
    checkOutput("rst_tick",       32'(o_mpc_tick),     32'd0);
    checkOutput("rst_valid",      32'(o_sample_valid), 32'd0);
    checkOutput("rst_overrun",    32'(o_overrun),      32'd0);
    checkOutput("rst_tick_count", 32'(o_tick_count),   32'd0);
    checkOutput("rst_vpv_s",      o_Vpv_s,             32'd0);
    checkOutput("rst_vout_pass",  o_Vout,              32'h33);

    // T1: default period, ready held high.
    $display("[TB] T1 default period");
    i_reset_n = 1'b1;
    stepCycles(1);
    i_enable = 1'b1;
    waitTick(DEF_P + 20, waited);
    expTicks++;
    checkOutput("t1_first_latency", 32'(waited),         32'(DEF_P + 1));
    checkOutput("t1_cnt_at_tick",   32'(dut.cnt_q),      32'd0);
    checkOutput("t1_tick_count1",   32'(o_tick_count),   32'(expTicks));
    checkOutput("t1_valid",         32'(o_sample_valid), 32'd1);
    checkOutput("t1_vpv_s",         o_Vpv_s,             32'h11);
    checkOutput("t1_ipv_s",         o_Ipv_s,             32'h22);
    checkOutput("t1_vout_s",        o_Vout_s,            32'h33);
    stepCycles(1);
    checkOutput("t1_tick_width",    32'(o_mpc_tick),     32'd0);
    checkOutput("t1_accepted",      32'(o_sample_valid), 32'd0);
    waitTick(DEF_P + 20, waited);
    expTicks++;
    checkOutput("t1_spacing",       32'(waited + 1),     32'(DEF_P));
    checkOutput("t1_cnt_at_tick2",  32'(dut.cnt_q),      32'd0);
    checkOutput("t1_tick_count2",   32'(o_tick_count),   32'(expTicks));
    checkOutput("t1_no_overrun",    32'(o_overrun),      32'd0);

    // T2: load 10 mid-period, then try an illegal period of 1.
    $display("[TB] T2 period load");
    stepCycles(1000);
    i_period      = 16'd10;
    i_period_load = 1'b1;
    stepCycles(1);
    i_period_load = 1'b0;
    waitTick(DEF_P, waited);
    expTicks++;
    checkOutput("t2_old_period_done", 32'(waited), 32'(DEF_P - 1001));
    waitTick(40, waited);
    expTicks++;
    checkOutput("t2_spacing10", 32'(waited), 32'd10);
    i_period      = 16'd1;
    i_period_load = 1'b1;
    stepCycles(1);
    i_period_load = 1'b0;
    waitTick(40, waited);
    expTicks++;
    checkOutput("t2_ignore1_a", 32'(waited + 1), 32'd10);
    waitTick(40, waited);
    expTicks++;
    checkOutput("t2_ignore1_b", 32'(waited), 32'd10);
    i_period      = 16'd8;
    i_period_load = 1'b1;
    stepCycles(1);
    i_period_load = 1'b0;
    waitTick(40, waited);
    expTicks++;
    checkOutput("t2_load8_pending", 32'(waited + 1), 32'd10);
    waitTick(40, waited);
    expTicks++;
    checkOutput("t2_spacing8",  32'(waited),       32'd8);
    checkOutput("t2_tick_count", 32'(o_tick_count), 32'(expTicks));

    // T3: ready low, two captures back to back produce an overrun.
    $display("[TB] T3 overrun");
    stepCycles(1);
    checkOutput("t3_drained", 32'(o_sample_valid), 32'd0);
    i_sample_ready = 1'b0;
    applyStimulus(32'd100, 32'h22, 32'h33);
    waitTick(40, waited);
    expTicks++;
    checkOutput("t3_spacing_a",  32'(waited + 1),    32'd8);
    checkOutput("t3_vpv_100",    o_Vpv_s,             32'd100);
    checkOutput("t3_valid_a",    32'(o_sample_valid), 32'd1);
    checkOutput("t3_no_ovr_yet", 32'(o_overrun),      32'd0);
    applyStimulus(32'd200, 32'h22, 32'h33);
    waitTick(40, waited);
    expTicks++;
    checkOutput("t3_vpv_200",   o_Vpv_s,             32'd200);
    checkOutput("t3_valid_b",   32'(o_sample_valid), 32'd1);
    checkOutput("t3_overrun",   32'(o_overrun),      32'd1);
    stepCycles(7);
    i_overrun_clr = 1'b1;
    applyStimulus(32'd300, 32'h22, 32'h33);
    stepCycles(1);
    expTicks++;
    checkOutput("t3_clr_tick",     32'(o_mpc_tick), 32'd1);
    checkOutput("t3_set_wins",     32'(o_overrun),  32'd1);
    checkOutput("t3_vpv_300",      o_Vpv_s,         32'd300);
    stepCycles(1);
    i_overrun_clr = 1'b0;
    checkOutput("t3_clr_alone",    32'(o_overrun),  32'd0);

    // T4: ready exactly on the tick edge, then ready one cycle late.
    $display("[TB] T4 handshake on tick edge");
    stepCycles(6);
    i_sample_ready = 1'b1;
    applyStimulus(32'd400, 32'h22, 32'h33);
    stepCycles(1);
    expTicks++;
    i_sample_ready = 1'b0;
    checkOutput("t4_tick",        32'(o_mpc_tick),     32'd1);
    checkOutput("t4_valid_kept",  32'(o_sample_valid), 32'd1);
    checkOutput("t4_vpv_400",     o_Vpv_s,             32'd400);
    checkOutput("t4_no_overrun",  32'(o_overrun),      32'd0);
    applyStimulus(32'd999, 32'h22, 32'h33);
    stepCycles(1);
    checkOutput("t4_held_valid",  32'(o_sample_valid), 32'd1);
    checkOutput("t4_held_vpv",    o_Vpv_s,             32'd400);
    i_sample_ready = 1'b1;
    stepCycles(1);
    i_sample_ready = 1'b0;
    checkOutput("t4_late_accept", 32'(o_sample_valid), 32'd0);

    // T5: disable at counter 5, sample stays pending across IDLE.
    $display("[TB] T5 enable drop");
    applyStimulus(32'd500, 32'h22, 32'h33);
    waitTick(40, waited);
    expTicks++;
    checkOutput("t5_spacing",     32'(waited + 2),     32'd8);
    checkOutput("t5_vpv_500",     o_Vpv_s,             32'd500);
    stepCycles(5);
    checkOutput("t5_cnt5",        32'(dut.cnt_q),      32'd5);
    i_enable = 1'b0;
    applyStimulus(32'd600, 32'h22, 32'h33);
    stepCycles(1);
    checkOutput("t5_cnt_cleared", 32'(dut.cnt_q),      32'd0);
    waitTick(12, waited);
    checkOutput("t5_no_tick",     32'(waited),         32'd12);
    checkOutput("t5_idle_valid",  32'(o_sample_valid), 32'd1);
    checkOutput("t5_idle_vpv",    o_Vpv_s,             32'd500);
    checkOutput("t5_idle_count",  32'(o_tick_count),   32'(expTicks));
    i_enable = 1'b1;
    waitTick(40, waited);
    expTicks++;
    checkOutput("t5_reenable_lat", 32'(waited),        32'd9);
    checkOutput("t5_vpv_600",     o_Vpv_s,             32'd600);
    checkOutput("t5_overrun",     32'(o_overrun),      32'd1);
    checkOutput("t5_tick_count",  32'(o_tick_count),   32'(expTicks));

    // T6: reset with valid, overrun and a pending load all outstanding.
    $display("[TB] T6 reset mid-operation");
    i_period      = 16'd20;
    i_period_load = 1'b1;
    stepCycles(1);
    i_period_load = 1'b0;
    stepCycles(2);
    i_reset_n = 1'b0;
    applyStimulus(32'd700, 32'h22, 32'hABCD);
    #1;
    checkOutput("t6_vout_pass_a", o_Vout, 32'hABCD);
    stepCycles(1);
    checkOutput("t6_tick",        32'(o_mpc_tick),     32'd0);
    checkOutput("t6_valid",       32'(o_sample_valid), 32'd0);
    checkOutput("t6_overrun",     32'(o_overrun),      32'd0);
    checkOutput("t6_tick_count",  32'(o_tick_count),   32'd0);
    checkOutput("t6_vpv_s",       o_Vpv_s,             32'd0);
    checkOutput("t6_ipv_s",       o_Ipv_s,             32'd0);
    checkOutput("t6_vout_s",      o_Vout_s,            32'd0);
    checkOutput("t6_period_def",  32'(dut.period_q),   32'(DEF_P));
    checkOutput("t6_shadow_def",  32'(dut.shadow_q),   32'(DEF_P));
    applyStimulus(32'd700, 32'h22, 32'h1234);
    #1;
    checkOutput("t6_vout_pass_b", o_Vout, 32'h1234);
    i_reset_n = 1'b1;
    waitTick(DEF_P + 20, waited);
    checkOutput("t6_default_lat", 32'(waited),       32'(DEF_P + 1));
    checkOutput("t6_count_restart", 32'(o_tick_count), 32'd1);
    checkOutput("t6_vout_capture", o_Vout_s,         32'h1234);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
